// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default sizes.
package data_mem_responder_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_MEM_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Synchronous single-port word RAM, write-first, contents not reset.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_MEM_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             WE,
    input  logic [AW-1:0]    ADDR,
    input  logic [WIDTH-1:0] WDATA,
    output logic [WIDTH-1:0] RDATA
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge CLK) begin
        if (WE) begin
            r_mem[ADDR] <= WDATA;
            r_rdata     <= WDATA;
        end else begin
            r_rdata     <= r_mem[ADDR];
        end
    end

    assign RDATA = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: latches a word request, waits WAIT_STATES cycles,
// then answers with a one-cycle MemReady strobe (plus MemErr for rejected accesses).
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int MEM_DEPTH   = DEFAULT_MEM_DEPTH,
    parameter int WAIT_STATES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MemReq,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] ReadData,
    output logic             MemReady,
    output logic             MemErr,
    output logic             Busy,
    output logic [1:0]       o_dbg_state
);

    // Handshake: MemReq is a level held by the core until MemReady; it is only
    // sampled in IDLE, dropping it during WAIT aborts, and MemReady is a single
    // strobe that ends the transaction (the next request is taken the cycle after).

    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
            $error("data_mem_responder: WAIT_STATES must be within 0..15");
        end
    endgenerate

    localparam int                AW      = $clog2(MEM_DEPTH);
    localparam logic [3:0]        WS4     = 4'(WAIT_STATES);
    localparam logic [WIDTH-3:0]  DEPTH_W = (WIDTH-2)'(MEM_DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             w_accept;
    logic             w_req_err;

    logic [AW-1:0]    r_idx;
    logic [WIDTH-1:0] r_wdata;
    logic             r_write;
    logic             r_err;

    logic [AW-1:0]    w_ram_addr;
    logic [WIDTH-1:0] w_ram_rdata;
    logic             w_ram_we;

    assign w_req_err = (ALUOut[1:0] != 2'b00) || (ALUOut[WIDTH-1:2] >= DEPTH_W);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MemReq) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = WS4;
                    w_state_nxt = (WS4 == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!MemReq) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_idx   <= ALUOut[AW+1:2];
                r_wdata <= WriteData;
                r_write <= MemWrite;
                r_err   <= w_req_err;
            end
        end
    end

    // The acceptance edge reads straight from ALUOut so a zero-wait load still
    // has its RAM word registered in time for the RESP cycle.
    assign w_ram_addr = (r_state == ST_IDLE) ? ALUOut[AW+1:2] : r_idx;
    assign w_ram_we   = (r_state == ST_RESP) && r_write && !r_err && !RST;

    data_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_array (
        .CLK   (CLK),
        .WE    (w_ram_we),
        .ADDR  (w_ram_addr),
        .WDATA (r_wdata),
        .RDATA (w_ram_rdata)
    );

    assign MemReady    = (r_state == ST_RESP);
    assign MemErr      = (r_state == ST_RESP) && r_err;
    assign Busy        = (r_state == ST_WAIT) || (r_state == ST_RESP);
    assign ReadData    = ((r_state == ST_RESP) && !r_write && !r_err) ? w_ram_rdata : '0;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: a WAIT_STATES=2 instance (a) and a WAIT_STATES=0 instance (b)
// share address/data buses; each has its own MemReq.
module tb_data_mem_responder;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] alu_out = '0;
    logic [31:0] write_data = '0;

    logic [31:0] rdata_a, rdata_b;
    logic        rdy_a, rdy_b, err_a, err_b, busy_a, busy_b;
    logic [1:0]  st_a, st_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rdy_cyc = 0;

    logic [31:0] exp_q[$];
    logic        err_q[$];
    logic [31:0] mdl_a [0:255];
    logic [31:0] mdl_b [0:255];

    data_mem_responder #(.WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(WS)) dut_a (
        .CLK(clk), .RST(rst), .MemReq(req_a), .MemWrite(mem_write),
        .ALUOut(alu_out), .WriteData(write_data), .ReadData(rdata_a),
        .MemReady(rdy_a), .MemErr(err_a), .Busy(busy_a), .o_dbg_state(st_a)
    );

    data_mem_responder #(.WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
        .CLK(clk), .RST(rst), .MemReq(req_b), .MemWrite(mem_write),
        .ALUOut(alu_out), .WriteData(write_data), .ReadData(rdata_b),
        .MemReady(rdy_b), .MemErr(err_b), .Busy(busy_b), .o_dbg_state(st_b)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on instance a (sel=0) or b (sel=1). Called at posedge+1.
    task automatic run_txn(input bit sel, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit hold, input bit scramble,
                           input string name);
        int          lat;
        int          c;
        bit          seen;
        bit          bad;
        logic [7:0]  idx;
        logic        rdy, busy, err;
        logic [31:0] rd, ed;
        logic        ee;
        lat = sel ? 1 : WS + 1;
        idx = addr[9:2];
        bad = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        if (bad) begin
            exp_q.push_back(32'h0); err_q.push_back(1'b1);
        end else if (wr) begin
            exp_q.push_back(32'h0); err_q.push_back(1'b0);
            if (sel) mdl_b[idx] = wdata; else mdl_a[idx] = wdata;
        end else begin
            exp_q.push_back(sel ? mdl_b[idx] : mdl_a[idx]); err_q.push_back(1'b0);
        end
        mem_write  = wr;
        alu_out    = addr;
        write_data = wdata;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        c = 0;
        seen = 1'b0;
        while (!seen && c <= lat + 4) begin
            @(negedge clk);
            rdy  = sel ? rdy_b : rdy_a;
            busy = sel ? busy_b : busy_a;
            err  = sel ? err_b : err_a;
            rd   = sel ? rdata_b : rdata_a;
            checks++;
            if (busy !== (c > 0)) begin
                $display("FAIL %s busy c=%0d: got %b want %b", name, c, busy, (c > 0));
                errors++;
            end
            if (rdy === 1'b1) begin
                seen = 1'b1;
                last_rdy_cyc = cyc;
                ed = exp_q.pop_front();
                ee = err_q.pop_front();
                checks += 3;
                if (c != lat) begin
                    $display("FAIL %s latency: got %0d want %0d", name, c, lat);
                    errors++;
                end
                if (rd !== ed) begin
                    $display("FAIL %s rdata: got %h want %h", name, rd, ed);
                    errors++;
                end
                if (err !== ee) begin
                    $display("FAIL %s memerr: got %b want %b", name, err, ee);
                    errors++;
                end
            end else begin
                @(posedge clk); #1;
                c++;
                if (scramble) begin
                    alu_out    = $urandom;
                    write_data = $urandom;
                end
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL %s timeout: got no MemReady want one within %0d cycles", name, lat);
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
        end
        @(posedge clk); #1;
        if (!hold) begin
            req_a = 1'b0; req_b = 1'b0;
            @(negedge clk);
            rdy  = sel ? rdy_b : rdy_a;
            busy = sel ? busy_b : busy_a;
            rd   = sel ? rdata_b : rdata_a;
            checks++;
            if (rdy !== 1'b0 || busy !== 1'b0 || rd !== 32'h0) begin
                $display("FAIL %s after: got rdy=%b busy=%b rdata=%h want 0/0/0", name, rdy, busy, rd);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 2;
        if ({rdata_a, rdy_a, err_a, busy_a, st_a} !== 37'h0) begin
            $display("FAIL reset_a: got rdata=%h rdy=%b err=%b busy=%b st=%0d want all 0",
                     rdata_a, rdy_a, err_a, busy_a, st_a);
            errors++;
        end
        if ({rdata_b, rdy_b, err_b, busy_b, st_b} !== 37'h0) begin
            $display("FAIL reset_b: got rdata=%h rdy=%b err=%b busy=%b st=%0d want all 0",
                     rdata_b, rdy_b, err_b, busy_b, st_b);
            errors++;
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 0, "store_10");
        run_txn(0, 1'b0, 32'h10, 32'h0, 0, 0, "load_10");
    endtask

    task automatic test_zero_wait();
        run_txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 0, 0, "zw_store");
        run_txn(1, 1'b0, 32'h10, 32'h0, 0, 0, "zw_load");
    endtask

    task automatic test_errors();
        run_txn(0, 1'b1, 32'h13, 32'h12345678, 0, 0, "misaligned_store");
        run_txn(0, 1'b0, 32'h10, 32'h0, 0, 0, "load_after_misaligned");
        run_txn(0, 1'b0, 32'h400, 32'h0, 0, 0, "out_of_range_load");
        run_txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, 0, 0, "out_of_range_store");
    endtask

    task automatic test_abort();
        run_txn(0, 1'b1, 32'h20, 32'h11112222, 0, 0, "store_20");
        // MemReq dropped during WAIT
        mem_write = 1'b1; alu_out = 32'h20; write_data = 32'h55556666; req_a = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (st_a !== 2'd1) begin
            $display("FAIL abort_in_wait: got state %0d want 1", st_a);
            errors++;
        end
        req_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (rdy_a !== 1'b0 || rdata_a !== 32'h0) begin
                $display("FAIL abort_quiet %0d: got rdy=%b rdata=%h want 0/0", i, rdy_a, rdata_a);
                errors++;
            end
        end
        @(posedge clk); #1;
        run_txn(0, 1'b0, 32'h20, 32'h0, 0, 0, "load_20_after_abort");
        // RST pulsed during WAIT while MemReq is still held
        mem_write = 1'b1; alu_out = 32'h20; write_data = 32'h33334444; req_a = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdata_a, rdy_a, err_a, busy_a, st_a} !== 37'h0) begin
            $display("FAIL rst_abort: got rdata=%h rdy=%b err=%b busy=%b st=%0d want all 0",
                     rdata_a, rdy_a, err_a, busy_a, st_a);
            errors++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rdy_a !== 1'b0) begin
                $display("FAIL rst_quiet %0d: got rdy=%b want 0", i, rdy_a);
                errors++;
            end
        end
        @(posedge clk); #1;
        run_txn(0, 1'b0, 32'h20, 32'h0, 0, 0, "load_20_after_rst");
    endtask

    task automatic test_back_to_back();
        int first;
        run_txn(0, 1'b0, 32'h10, 32'h0, 1, 1, "b2b_first");
        first = last_rdy_cyc;
        run_txn(0, 1'b0, 32'h20, 32'h0, 0, 1, "b2b_second");
        checks++;
        if (last_rdy_cyc - first != WS + 2) begin
            $display("FAIL b2b_spacing: got %0d want %0d", last_rdy_cyc - first, WS + 2);
            errors++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 6; i++) begin
            a = {22'h0, 8'($urandom_range(64, 79)), 2'b00};
            run_txn(0, 1'b1, a, $urandom, 0, 0, "rand_store");
            run_txn(0, 1'b0, a, 32'h0, 0, i[0], "rand_load");
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_zero_wait();
        test_errors();
        test_abort();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
